addr_match_engine: RTL and testbench

ADDR_MATCH_ENGINE -- requirements
Module: addr_match_engine

---
 rtl/amatch_pkg.sv | 8 +
 rtl/amatch_slot.sv | 41 ++++
 rtl/addr_match_engine.sv | 132 +++++++++++++
 tb/tb_addr_match_engine.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amatch_pkg.sv
// Shared constants and types for the address/pattern match engine.
package amatch_pkg;
  localparam int unsigned DEF_NUM_PAT   = 4;
  localparam int unsigned DEF_PAT_BYTES = 4;
  localparam int unsigned DEF_BUS_BYTES = 4;

  typedef logic [7:0] byte_t;
endpackage

// File: rtl/amatch_slot.sv
// One programmable pattern register and its compare across every alignment
// that ends in the newest beat of the window.
module amatch_slot
  import amatch_pkg::*;
#(
  parameter int unsigned PAT_BYTES = DEF_PAT_BYTES,
  parameter int unsigned BUS_BYTES = DEF_BUS_BYTES,
  localparam int unsigned W = PAT_BYTES + BUS_BYTES - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [8*PAT_BYTES-1:0] wr_data,
  input  logic                   wr_en,
  input  logic [8*W-1:0]         win,
  input  logic [BUS_BYTES-1:0]   align_ok,
  output logic                   hit
);
  logic [8*PAT_BYTES-1:0] pat;
  logic                   en;
  logic [BUS_BYTES-1:0]   eq;

  always_ff @(posedge clk) begin
    if (rst) begin
      pat <= '0;
      en  <= 1'b0;
    end else if (wr) begin
      pat <= wr_data;
      en  <= wr_en;
    end
  end

  // Alignment a covers window bytes a .. a+PAT_BYTES-1.
  always_comb begin
    eq = '0;
    for (int unsigned a = 0; a < BUS_BYTES; a++)
      eq[a] = (win[8*a +: 8*PAT_BYTES] == pat);
  end

  assign hit = en && |(eq & align_ok);
endmodule

// File: rtl/addr_match_engine.sv
// Streaming multi-pattern byte matcher: two-stage pipeline (window shift,
// then compare/sticky update) with per-frame verdict on the last beat.
module addr_match_engine
  import amatch_pkg::*;
#(
  parameter int unsigned NUM_PAT   = DEF_NUM_PAT,
  parameter int unsigned PAT_BYTES = DEF_PAT_BYTES,
  parameter int unsigned BUS_BYTES = DEF_BUS_BYTES,
  localparam int unsigned IDXW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   pat_wr,
  input  logic [IDXW-1:0]        pat_idx,
  input  logic [8*PAT_BYTES-1:0] pat_data,
  input  logic                   pat_en,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [8*BUS_BYTES-1:0] data_in,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [8*BUS_BYTES-1:0] data_out,
  output logic [NUM_PAT-1:0]     match_vec,
  output logic                   match,
  output logic [IDXW-1:0]        match_idx,
  output logic                   frame_done
);
  localparam int unsigned W    = PAT_BYTES + BUS_BYTES - 1;
  localparam int unsigned KEEP = PAT_BYTES - 1;
  localparam int unsigned CW   = $clog2(W + BUS_BYTES + 1);
  localparam logic [CW-1:0] CNT_BEAT = CW'(BUS_BYTES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(W);

  logic [8*W-1:0]         win_q;
  logic [CW-1:0]          cnt_q;
  logic [CW:0]            cnt_sum;
  logic                   new_frame;
  logic                   v1, l1, first1;
  logic [8*BUS_BYTES-1:0] d1;
  logic [BUS_BYTES-1:0]   align_ok;
  logic [NUM_PAT-1:0]     slot_wr;
  logic [NUM_PAT-1:0]     hits;

  assign cnt_sum = {1'b0, cnt_q} + {1'b0, CNT_BEAT};

  // Stage 1: newest beat lands in the top BUS_BYTES of the window; a new
  // frame starts from an all-zero window with only this beat counted.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      win_q     <= '0;
      cnt_q     <= '0;
      new_frame <= 1'b1;
      v1        <= 1'b0;
      l1        <= 1'b0;
      first1    <= 1'b0;
      d1        <= '0;
    end else begin
      v1 <= in_valid;
      l1 <= in_valid && in_last;
      if (in_valid) begin
        d1        <= data_in;
        first1    <= new_frame;
        new_frame <= in_last;
        if (new_frame) begin
          win_q <= {data_in, {(8*KEEP){1'b0}}};
          cnt_q <= CNT_BEAT;
        end else begin
          win_q <= {data_in, win_q[8*W-1 -: 8*KEEP]};
          cnt_q <= (cnt_sum >= {1'b0, CNT_MAX}) ? CNT_MAX : cnt_sum[CW-1:0];
        end
      end
    end
  end

  // Alignment a ends BUS_BYTES-1-a bytes before the newest byte, so it needs
  // W-a real frame bytes in the window.
  always_comb begin
    align_ok = '0;
    for (int unsigned a = 0; a < BUS_BYTES; a++)
      align_ok[a] = (32'(cnt_q) >= (W - a));
  end

  always_comb begin
    slot_wr = '0;
    for (int unsigned i = 0; i < NUM_PAT; i++)
      slot_wr[i] = pat_wr && (32'(pat_idx) == i);
  end

  for (genvar g = 0; g < NUM_PAT; g++) begin : g_slot
    amatch_slot #(
      .PAT_BYTES(PAT_BYTES),
      .BUS_BYTES(BUS_BYTES)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr      (slot_wr[g]),
      .wr_data (pat_data),
      .wr_en   (pat_en),
      .win     (win_q),
      .align_ok(align_ok),
      .hit     (hits[g])
    );
  end

  // Stage 2: sticky flags restart on the first beat of each frame.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
      match_vec  <= '0;
    end else begin
      out_valid  <= v1;
      out_last   <= l1;
      frame_done <= l1;
      if (v1) begin
        data_out  <= d1;
        match_vec <= (first1 ? '0 : match_vec) | hits;
      end
    end
  end

  assign match = |match_vec;

  always_comb begin
    match_idx = '0;
    for (int unsigned i = NUM_PAT; i > 0; i--)
      if (match_vec[i-1]) match_idx = IDXW'(i - 1);
  end
endmodule

// File: tb/tb_addr_match_engine.sv
// Scoreboarded bench: a default-size engine checked beat by beat against a
// byte-stream model, plus a MAC-width engine for three-beat spans and timing.
module tb_addr_match_engine;
  import amatch_pkg::*;

  localparam int NP = 4;
  localparam int PB = 4;
  localparam int BB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        clear = 1'b0, pat_wr = 1'b0, pat_en = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [1:0]  pat_idx = '0;
  logic [31:0] pat_data = '0, data_in = '0;
  logic        out_valid, out_last, match, frame_done;
  logic [31:0] data_out;
  logic [3:0]  match_vec;
  logic [1:0]  match_idx;

  logic        m_clear = 1'b0, m_pat_wr = 1'b0, m_pat_en = 1'b0;
  logic        m_in_valid = 1'b0, m_in_last = 1'b0;
  logic [1:0]  m_pat_idx = '0;
  logic [47:0] m_pat_data = '0;
  logic [31:0] m_data_in = '0;
  logic        m_out_valid, m_out_last, m_match, m_frame_done;
  logic [31:0] m_data_out;
  logic [2:0]  m_match_vec;
  logic [1:0]  m_match_idx;

  addr_match_engine #(.NUM_PAT(4), .PAT_BYTES(4), .BUS_BYTES(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .pat_wr(pat_wr), .pat_idx(pat_idx),
    .pat_data(pat_data), .pat_en(pat_en), .in_valid(in_valid), .in_last(in_last),
    .data_in(data_in), .out_valid(out_valid), .out_last(out_last),
    .data_out(data_out), .match_vec(match_vec), .match(match),
    .match_idx(match_idx), .frame_done(frame_done)
  );

  addr_match_engine #(.NUM_PAT(3), .PAT_BYTES(6), .BUS_BYTES(4)) dut_mac (
    .clk(clk), .rst(rst), .clear(m_clear), .pat_wr(m_pat_wr), .pat_idx(m_pat_idx),
    .pat_data(m_pat_data), .pat_en(m_pat_en), .in_valid(m_in_valid),
    .in_last(m_in_last), .data_in(m_data_in), .out_valid(m_out_valid),
    .out_last(m_out_last), .data_out(m_data_out), .match_vec(m_match_vec),
    .match(m_match), .match_idx(m_match_idx), .frame_done(m_frame_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  mvec;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  byte_t       fb[$];
  logic [31:0] mp_val[NP];
  logic        mp_on[NP];
  logic [3:0]  sticky = '0;
  bit          fresh = 1'b1;

  initial begin
    for (int i = 0; i < NP; i++) begin
      mp_val[i] = '0;
      mp_on[i]  = 1'b0;
    end
  end

  // Reference: sticky flag set when a pattern occurs anywhere in the frame's
  // byte stream with its last byte inside the newest beat.
  task automatic model_beat(input logic l, input logic [31:0] d);
    exp_t e;
    int   n;
    bit   ok;
    if (fresh) begin
      fb.delete();
      sticky = '0;
    end
    for (int j = 0; j < BB; j++) fb.push_back(d[8*j +: 8]);
    n = fb.size();
    for (int i = 0; i < NP; i++) begin
      if (mp_on[i]) begin
        for (int s = n - BB - PB + 1; s <= n - PB; s++) begin
          if (s >= 0) begin
            ok = 1'b1;
            for (int k = 0; k < PB; k++)
              if (fb[s+k] !== mp_val[i][8*k +: 8]) ok = 1'b0;
            if (ok) sticky[i] = 1'b1;
          end
        end
      end
    end
    fresh  = l;
    e.data = d;
    e.last = l;
    e.mvec = sticky;
    e.cyc  = cyc + 2;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   li;
    if (!rst) begin
      if (out_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: out_valid=1 with data %h, no beat expected", data_out);
        end else begin
          e = sbq.pop_front();
          li = 0;
          for (int i = NP - 1; i >= 0; i--) if (e.mvec[i]) li = i;
          if ({data_out, out_last, frame_done, match_vec, match, match_idx} !==
              {e.data, e.last, e.last, e.mvec, |e.mvec, 2'(li)}) begin
            errors++;
            $display("FAIL sb_beat: got data=%h last=%b done=%b vec=%b m=%b idx=%0d want data=%h last=%b done=%b vec=%b m=%b idx=%0d",
                     data_out, out_last, frame_done, match_vec, match, match_idx,
                     e.data, e.last, e.last, e.mvec, |e.mvec, li);
          end
          checks++;
          if (cyc !== e.cyc) begin
            errors++;
            $display("FAIL sb_latency: got cycle %0d want %0d", cyc, e.cyc);
          end
        end
      end else if (frame_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL sb_done_idle: got frame_done=%b want 0", frame_done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic [31:0] d);
    in_valid = 1'b1;
    in_last  = l;
    data_in  = d;
    model_beat(l, d);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wr_pat(input int idx, input logic [31:0] v, input logic en);
    pat_wr   = 1'b1;
    pat_idx  = 2'(idx);
    pat_data = v;
    pat_en   = en;
    tick();
    pat_wr = 1'b0;
    mp_val[idx] = v;
    mp_on[idx]  = en;
  endtask

  task automatic m_wr(input logic [1:0] idx, input logic [47:0] v, input logic en);
    m_pat_wr   = 1'b1;
    m_pat_idx  = idx;
    m_pat_data = v;
    m_pat_en   = en;
    tick();
    m_pat_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b1; in_valid = 1'b1; in_last = 1'b1; data_in = '1;
    pat_wr = 1'b1; pat_idx = 2'd0; pat_data = '1; pat_en = 1'b1;
    m_pat_wr = 1'b1; m_pat_idx = 2'd0; m_pat_data = '1; m_pat_en = 1'b1;
    m_in_valid = 1'b1; m_in_last = 1'b1; m_data_in = '1;
    repeat (3) tick();
    checks++;
    if ({out_valid, out_last, frame_done, match, data_out, match_vec, match_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%b m=%b data=%h vec=%b idx=%0d want all zero",
               out_valid, out_last, frame_done, match, data_out, match_vec, match_idx);
    end
    checks++;
    if ({m_out_valid, m_out_last, m_frame_done, m_match, m_data_out, m_match_vec, m_match_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_mac: got v=%b vec=%b data=%h want zero", m_out_valid, m_match_vec, m_data_out);
    end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; pat_wr = 1'b0;
    m_pat_wr = 1'b0; m_in_valid = 1'b0; m_in_last = 1'b0;
    tick();
    // A pattern write held during reset must not have landed.
    drive(1'b1, 32'hFFFFFFFF);
    tick();
    checks++;
    if (frame_done !== 1'b1 || match_vec !== 4'b0000) begin
      errors++;
      $display("FAIL reset_patterns: got done=%b vec=%b want done=1 vec=0000", frame_done, match_vec);
    end
  endtask

  task automatic test_single_beat();
    wr_pat(0, 32'h0A01A8C0, 1'b1);
    drive(1'b1, 32'h0A01A8C0);
    tick();
    checks++;
    if (frame_done !== 1'b1 || match_vec !== 4'b0001 || match_idx !== 2'd0) begin
      errors++;
      $display("FAIL single_beat: got done=%b vec=%b idx=%0d want 1 0001 0", frame_done, match_vec, match_idx);
    end
  endtask

  task automatic test_cross_boundary();
    drive(1'b0, 32'hA8C02211);
    drive(1'b1, 32'h66550A01);
    checks++;
    if (out_valid !== 1'b1 || match_vec !== 4'b0000) begin
      errors++;
      $display("FAIL cross_first_beat: got v=%b vec=%b want 1 0000", out_valid, match_vec);
    end
    tick();
    checks++;
    if (frame_done !== 1'b1 || match !== 1'b1) begin
      errors++;
      $display("FAIL cross_verdict: got done=%b match=%b want 1 1", frame_done, match);
    end
  endtask

  task automatic test_zero_pattern();
    wr_pat(0, 32'h0, 1'b0);
    wr_pat(2, 32'h0, 1'b1);
    drive(1'b1, 32'h44332211);
    tick();
    checks++;
    if (frame_done !== 1'b1 || match !== 1'b0) begin
      errors++;
      $display("FAIL zero_no_false_hit: got done=%b match=%b want 1 0", frame_done, match);
    end
    drive(1'b1, 32'h00000000);
    tick();
    checks++;
    if (match_vec !== 4'b0100 || match_idx !== 2'd2) begin
      errors++;
      $display("FAIL zero_real_hit: got vec=%b idx=%0d want 0100 2", match_vec, match_idx);
    end
  endtask

  task automatic test_back_to_back();
    wr_pat(2, 32'h0, 1'b0);
    wr_pat(1, 32'hDDCCBBAA, 1'b1);
    wr_pat(3, 32'h44332211, 1'b1);
    drive(1'b0, 32'hDDCCBBAA);
    drive(1'b1, 32'h44332211);
    drive(1'b1, 32'h12345678);
    checks++;
    if (frame_done !== 1'b1 || match_vec !== 4'b1010 || match_idx !== 2'd1) begin
      errors++;
      $display("FAIL multi_hit: got done=%b vec=%b idx=%0d want 1 1010 1", frame_done, match_vec, match_idx);
    end
    tick();
    checks++;
    if (frame_done !== 1'b1 || match_vec !== 4'b0000 || match_idx !== 2'd0) begin
      errors++;
      $display("FAIL no_hit_frame: got done=%b vec=%b idx=%0d want 1 0000 0", frame_done, match_vec, match_idx);
    end
    // AA BB ends one frame, CC DD starts the next: must not join.
    drive(1'b1, 32'hBBAA9988);
    drive(1'b1, 32'h0000DDCC);
    tick();
    checks++;
    if (frame_done !== 1'b1 || match_vec !== 4'b0000) begin
      errors++;
      $display("FAIL frame_leak: got done=%b vec=%b want 1 0000", frame_done, match_vec);
    end
  endtask

  task automatic test_clear();
    drive(1'b0, 32'hDDCCBBAA);
    tick();
    checks++;
    if (match_vec !== 4'b0010) begin
      errors++;
      $display("FAIL clear_prehit: got vec=%b want 0010", match_vec);
    end
    clear = 1'b1; in_valid = 1'b1; in_last = 1'b1; data_in = 32'h44332211;
    pat_wr = 1'b1; pat_idx = 2'd0; pat_data = 32'h0D0C0B0A; pat_en = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; pat_wr = 1'b0;
    mp_val[0] = 32'h0D0C0B0A;
    mp_on[0]  = 1'b1;
    fresh     = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || match_vec !== 4'b0000) begin
      errors++;
      $display("FAIL clear_flush: got v=%b vec=%b want 0 0000", out_valid, match_vec);
    end
    drive(1'b1, 32'h0D0C0B0A);
    tick();
    checks++;
    if (frame_done !== 1'b1 || match_vec !== 4'b0001 || match_idx !== 2'd0) begin
      errors++;
      $display("FAIL clear_after: got done=%b vec=%b idx=%0d want 1 0001 0", frame_done, match_vec, match_idx);
    end
  endtask

  task automatic test_mac_three_beat();
    logic [9:0]  seq;
    logic [9:0]  ov;
    logic [31:0] beats[3];
    int          b;
    int          fd;
    seq = 10'b0000101001;
    m_wr(2'd0, 48'h5E4D3C2B1A00, 1'b1);
    m_wr(2'd1, 48'h665544332211, 1'b1);
    m_wr(2'd2, 48'h5E4D3C2B1A00, 1'b0);
    m_wr(2'd3, 48'h5E4D3C2B1A00, 1'b1);
    for (int f = 0; f < 2; f++) begin
      beats[0] = 32'h00777777;
      beats[1] = (f == 0) ? 32'h4D3C2B1A : 32'h4D3C2B1B;
      beats[2] = 32'h7777775E;
      b  = 0;
      fd = 0;
      ov = '0;
      for (int t = 0; t < 10; t++) begin
        m_in_valid = seq[t];
        m_in_last  = seq[t] && (b == 2);
        m_data_in  = seq[t] ? beats[b] : 32'h0;
        if (seq[t]) b++;
        tick();
        m_in_valid = 1'b0;
        m_in_last  = 1'b0;
        ov[t] = m_out_valid;
        if (m_frame_done === 1'b1) begin
          fd++;
          checks++;
          if (m_match_vec !== ((f == 0) ? 3'b001 : 3'b000) || m_data_out !== beats[2]) begin
            errors++;
            $display("FAIL mac_verdict: frame %0d got vec=%b data=%h want %b %h",
                     f, m_match_vec, m_data_out, (f == 0) ? 3'b001 : 3'b000, beats[2]);
          end
        end
      end
      for (int t = 0; t < 9; t++) begin
        checks++;
        if (ov[t+1] !== seq[t]) begin
          errors++;
          $display("FAIL mac_valid_delay: cycle %0d got out_valid=%b want %b", t + 2, ov[t+1], seq[t]);
        end
      end
      checks++;
      if (fd != 1) begin
        errors++;
        $display("FAIL mac_done_count: got %0d pulses want 1", fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_cross_boundary();
    test_zero_pattern();
    test_back_to_back();
    test_clear();
    test_mac_three_beat();
    repeat (4) tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d beats outstanding want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
